// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ stream: arbiter state encoding, the abort word,
// and the packet type codes used by the sensor engines.
package daq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

  localparam logic [31:0] DAQ_ABORT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    DAQT_NONE    = 4'h0,
    DAQT_AS5311  = 4'h1,
    DAQT_ENCODER = 4'h2,
    DAQT_ADC     = 4'h3,
    DAQT_STATUS  = 4'h4
  } daqt_e;

endpackage

// File: rtl/daq_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/daq_arbiter.sv
// Round-robin arbiter sharing the DAQ stream between sensor engines, one packet
// at a time, with over-length/stall protection and sticky per-requester errors.
module daq_arbiter
  import daq_pkg::*;
#(
  parameter int          NREQ       = 4,
  parameter int          MAX_PKT    = 4,
  parameter int          TIMEOUT    = 256,
  parameter int          FREE_BITS  = 10,
  parameter logic [31:0] ABORT_WORD = DAQ_ABORT_WORD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      grant,
  input  logic [32*NREQ-1:0]   in_data,
  input  logic [NREQ-1:0]      in_valid,
  input  logic [NREQ-1:0]      in_end,
  input  logic [FREE_BITS-1:0] fifo_free,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  output logic                 out_end,
  output logic [NREQ-1:0]      err_timeout,
  output logic [NREQ-1:0]      err_overlen,
  input  logic                 err_clear,
  output logic [15:0]          debug
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = $clog2(MAX_PKT + 1);

  localparam logic [FREE_BITS-1:0] FREE_NEED = FREE_BITS'(MAX_PKT + 1);
  localparam logic [TW-1:0]        TO_LIM    = TW'(TIMEOUT);
  localparam logic [WW-1:0]        WC_LIM    = WW'(MAX_PKT);
  localparam logic [WW-1:0]        WC_LAST   = WW'(MAX_PKT - 1);

  logic [1:0]      state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] owner_oh;
  logic [TW-1:0]   tcnt;
  logic [WW-1:0]   wcnt;
  logic            drain;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic [31:0]     own_data;
  logic            own_valid;
  logic            own_end;
  logic            accept;
  logic            word_end;
  logic            hit_max;
  logic            to_fire;
  logic            leave_xfer;
  logic [IW-1:0]   next_ptr;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_end   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_oh[i]) begin
        own_data  = in_data[32*i +: 32];
        own_valid = in_valid[i];
        own_end   = in_end[i];
      end
    end
  end

  // An end word arriving on the deadline cycle still closes the packet cleanly.
  assign accept     = (state == ST_XFER) && own_valid;
  assign word_end   = accept && own_end;
  assign hit_max    = accept && !drain && !own_end && (wcnt == WC_LAST);
  assign to_fire    = (state == ST_XFER) && (tcnt == TO_LIM) && !word_end;
  assign leave_xfer = word_end || to_fire;
  assign next_ptr   = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      owner     <= '0;
      owner_oh  <= '0;
      rr_ptr    <= '0;
      tcnt      <= '0;
      wcnt      <= '0;
      drain     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_end   <= 1'b0;
    end else begin
      grant     <= '0;
      out_valid <= 1'b0;
      out_end   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && pick_any && (fifo_free >= FREE_NEED)) begin
            state    <= ST_GRANT;
            grant    <= pick_oh;
            owner    <= pick_idx;
            owner_oh <= pick_oh;
          end
        end
        ST_GRANT: begin
          state <= ST_XFER;
          tcnt  <= '0;
          wcnt  <= '0;
          drain <= 1'b0;
        end
        ST_XFER: begin
          if (tcnt != TO_LIM) tcnt <= tcnt + 1'b1;
          if (to_fire) begin
            if (!drain) begin
              out_valid <= 1'b1;
              out_data  <= ABORT_WORD;
              out_end   <= 1'b1;
            end
          end else if (accept && !drain) begin
            out_valid <= 1'b1;
            out_data  <= own_data;
            out_end   <= own_end || hit_max;
            if (wcnt != WC_LIM) wcnt <= wcnt + 1'b1;
            if (hit_max) drain <= 1'b1;
          end
          if (leave_xfer) begin
            state  <= ST_IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A clear in the same cycle as a new error wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= '0;
      err_overlen <= '0;
    end else if (err_clear) begin
      err_timeout <= '0;
      err_overlen <= '0;
    end else begin
      err_timeout <= err_timeout | ({NREQ{to_fire}} & owner_oh);
      err_overlen <= err_overlen | ({NREQ{hit_max && !to_fire}} & owner_oh);
    end
  end

  always_comb begin
    debug      = '0;
    debug[1:0] = state;
    debug[3:2] = 2'(owner);
  end

endmodule
